// File: rtl/seq_mult_display.sv
// Sequential shift-add multiplier with a scanned 7-segment hex display of the last product.
// Define MULT_SIGNED_EN to treat a, b and product as two's complement.
module seq_mult_display #(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 100000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic [DIGITS-1:0]    sm_wei,
   output logic [7:0]           sm_duan
);

   localparam int PW     = 2 * WIDTH;
   localparam int STEP_W = $clog2(WIDTH);
   localparam int SC_W   = $clog2(SCAN_DIV);
   localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PAD_W  = (4 * DIGITS > PW) ? 4 * DIGITS : PW;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [PW-1:0]       r_acc;
   logic [PW-1:0]       r_mcand;
   logic [WIDTH-1:0]    r_mplier;
   logic [STEP_W-1:0]   r_step;
   logic                r_neg;
   logic                r_done;
   logic [PW-1:0]       r_product;
   logic [WIDTH-1:0]    w_a_mag;
   logic [WIDTH-1:0]    w_b_mag;
   logic                w_neg;
   logic [SC_W-1:0]     r_scan;
   logic [DIG_W-1:0]    r_digit;
   logic [DIGITS-1:0]   r_wei;
   logic [PAD_W-1:0]    w_padded;
   logic [3:0]          w_nibble;
   logic [6:0]          w_seg;

   // Signed mode multiplies magnitudes; the most negative value's magnitude still fits unsigned.
`ifdef MULT_SIGNED_EN
   assign w_a_mag = a[WIDTH-1] ? -a : a;
   assign w_b_mag = b[WIDTH-1] ? -b : b;
   assign w_neg   = a[WIDTH-1] ^ b[WIDTH-1];
`else
   assign w_a_mag = a;
   assign w_b_mag = b;
   assign w_neg   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = RUN;
         RUN:     if (r_step == STEP_W'(WIDTH - 1)) w_next = FIN;
         FIN:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_step    <= '0;
         r_neg     <= 1'b0;
         r_done    <= 1'b0;
         r_product <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mcand  <= PW'(w_a_mag);
                  r_mplier <= w_b_mag;
                  r_acc    <= '0;
                  r_step   <= '0;
                  r_neg    <= w_neg;
               end
            end
            RUN: begin
               if (r_mplier[0]) r_acc <= r_acc + r_mcand;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_step   <= r_step + 1'b1;
            end
            FIN: begin
               r_product <= r_neg ? -r_acc : r_acc;
               r_done    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Digit select rotates in step with the digit index so sm_wei stays one-hot of r_digit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_scan  <= '0;
         r_digit <= '0;
         r_wei   <= DIGITS'(1);
      end else if (r_scan == SC_W'(SCAN_DIV - 1)) begin
         r_scan <= '0;
         if (r_digit == DIG_W'(DIGITS - 1)) begin
            r_digit <= '0;
            r_wei   <= DIGITS'(1);
         end else begin
            r_digit <= r_digit + 1'b1;
            r_wei   <= r_wei << 1;
         end
      end else begin
         r_scan <= r_scan + 1'b1;
      end
   end

   assign w_padded = PAD_W'(r_product);
   assign w_nibble = 4'(w_padded >> {r_digit, 2'b00});

   always_comb begin
      w_seg = 7'h00;
      case (w_nibble)
         4'h0: w_seg = 7'h3F;
         4'h1: w_seg = 7'h06;
         4'h2: w_seg = 7'h5B;
         4'h3: w_seg = 7'h4F;
         4'h4: w_seg = 7'h66;
         4'h5: w_seg = 7'h6D;
         4'h6: w_seg = 7'h7D;
         4'h7: w_seg = 7'h07;
         4'h8: w_seg = 7'h7F;
         4'h9: w_seg = 7'h6F;
         4'hA: w_seg = 7'h77;
         4'hB: w_seg = 7'h7C;
         4'hC: w_seg = 7'h39;
         4'hD: w_seg = 7'h5E;
         4'hE: w_seg = 7'h79;
         4'hF: w_seg = 7'h71;
         default: w_seg = 7'h00;
      endcase
   end

   assign busy    = (r_state != IDLE);
   assign done    = r_done;
   assign product = r_product;
   assign sm_wei  = r_wei;
   assign sm_duan = {1'b0, w_seg};

endmodule

// File: tb/tb_seq_mult_display.sv
// Self-checking bench for seq_mult_display (WIDTH=8, DIGITS=4, SCAN_DIV=4) against an arithmetic model.
module tb_seq_mult_display;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic [3:0]  sm_wei;
   logic [7:0]  sm_duan;

   int nChecks = 0;
   int nPass   = 0;
   int tbCyc   = 0;

   logic [7:0] segTab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   seq_mult_display #(.WIDTH(8), .DIGITS(4), .SCAN_DIV(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product),
      .sm_wei  (sm_wei),
      .sm_duan (sm_duan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Clock edges since the last reset edge, used to predict the scan position.
   always @(posedge clk) begin
      if (!rst_n) tbCyc <= 0;
      else        tbCyc <= tbCyc + 1;
   end

   function automatic logic [15:0] modelMult(input logic [7:0] x, input logic [7:0] y);
      int sx;
      int sy;
`ifdef MULT_SIGNED_EN
      sx = x[7] ? int'(x) - 256 : int'(x);
      sy = y[7] ? int'(y) - 256 : int'(y);
`else
      sx = int'(x);
      sy = int'(y);
`endif
      return 16'(sx * sy);
   endfunction

   task automatic runMult(input logic [7:0] x, input logic [7:0] y, output int lat,
                          output int pulses, output logic [15:0] prod, output logic busyAfter);
      lat       = -1;
      pulses    = 0;
      prod      = '0;
      busyAfter = 1'b1;
      @(negedge clk);
      a     = x;
      b     = y;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a     = 8'($urandom_range(0, 255));
      b     = 8'($urandom_range(0, 255));
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            pulses++;
            if (lat < 0) begin
               lat       = k;
               prod      = product;
               busyAfter = busy;
            end
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b1;
      a     = 8'h12;
      b     = 8'h34;
      repeat (3) @(posedge clk);
      @(negedge clk);
      nChecks++;
      if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy);
      else nPass++;
      nChecks++;
      if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done);
      else nPass++;
      nChecks++;
      if (product !== 16'h0000) $display("[TB] FAIL reset_product: got %h expected 0000", product);
      else nPass++;
      nChecks++;
      if (sm_wei !== 4'b0001) $display("[TB] FAIL reset_wei: got %b expected 0001", sm_wei);
      else nPass++;
      nChecks++;
      if (sm_duan !== 8'h3F) $display("[TB] FAIL reset_duan: got %h expected 3f", sm_duan);
      else nPass++;
      start = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_directed;
      logic [7:0]  va [4] = '{8'h0C, 8'hFF, 8'h00, 8'hFF};
      logic [7:0]  vb [4] = '{8'h0D, 8'hFF, 8'hAB, 8'h02};
`ifdef MULT_SIGNED_EN
      logic [15:0] ve [4] = '{16'h009C, 16'h0001, 16'h0000, 16'hFFFE};
`else
      logic [15:0] ve [4] = '{16'h009C, 16'hFE01, 16'h0000, 16'h01FE};
`endif
      int          lat;
      int          pulses;
      logic [15:0] prod;
      logic        bAfter;
      for (int i = 0; i < 4; i++) begin
         runMult(va[i], vb[i], lat, pulses, prod, bAfter);
         nChecks++;
         if (lat != 9) $display("[TB] FAIL directed_latency[%0d]: got %0d expected 9", i, lat);
         else nPass++;
         nChecks++;
         if (prod !== ve[i]) $display("[TB] FAIL directed_product[%0d]: got %h expected %h", i, prod, ve[i]);
         else nPass++;
         nChecks++;
         if (pulses != 1) $display("[TB] FAIL directed_pulses[%0d]: got %0d expected 1", i, pulses);
         else nPass++;
         nChecks++;
         if (bAfter !== 1'b0) $display("[TB] FAIL directed_busy[%0d]: got %b expected 0", i, bAfter);
         else nPass++;
      end
   endtask

   task automatic test_random;
      int          lat;
      int          pulses;
      logic [15:0] prod;
      logic        bAfter;
      logic [7:0]  x;
      logic [7:0]  y;
      for (int i = 0; i < 12; i++) begin
         x = 8'($urandom_range(0, 255));
         y = 8'($urandom_range(0, 255));
         runMult(x, y, lat, pulses, prod, bAfter);
         nChecks++;
         if (lat != 9 || pulses != 1)
            $display("[TB] FAIL random_timing %h*%h: got lat %0d pulses %0d expected 9 and 1", x, y, lat, pulses);
         else nPass++;
         nChecks++;
         if (prod !== modelMult(x, y))
            $display("[TB] FAIL random_product %h*%h: got %h expected %h", x, y, prod, modelMult(x, y));
         else nPass++;
      end
   endtask

   task automatic test_ignore_start;
      int          lat;
      int          pulses;
      logic [15:0] prod;
      lat    = -1;
      pulses = 0;
      prod   = '0;
      @(negedge clk);
      a     = 8'h0C;
      b     = 8'h0D;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            pulses++;
            if (lat < 0) begin
               lat  = k;
               prod = product;
            end
         end
         start = (k == 3);
         if (k == 3) begin
            a = 8'h55;
            b = 8'h77;
         end
      end
      start = 1'b0;
      nChecks++;
      if (lat != 9) $display("[TB] FAIL ignore_latency: got %0d expected 9", lat);
      else nPass++;
      nChecks++;
      if (pulses != 1) $display("[TB] FAIL ignore_pulses: got %0d expected 1", pulses);
      else nPass++;
      nChecks++;
      if (prod !== 16'h009C) $display("[TB] FAIL ignore_product: got %h expected 009c", prod);
      else nPass++;
   endtask

   task automatic test_reset_during_run;
      int pulses;
      pulses = 0;
      @(negedge clk);
      a     = 8'hFF;
      b     = 8'hFF;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) pulses++;
      end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      nChecks++;
      if (busy !== 1'b0 || product !== 16'h0000)
         $display("[TB] FAIL abort_state: got busy %b product %h expected busy 0 product 0000", busy, product);
      else nPass++;
      nChecks++;
      if (sm_wei !== 4'b0001 || sm_duan !== 8'h3F)
         $display("[TB] FAIL abort_display: got wei %b duan %h expected 0001 3f", sm_wei, sm_duan);
      else nPass++;
      rst_n = 1'b1;
      for (int k = 0; k < 14; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) pulses++;
      end
      nChecks++;
      if (pulses != 0) $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", pulses);
      else nPass++;
      nChecks++;
      if (product !== 16'h0000) $display("[TB] FAIL abort_product_held: got %h expected 0000", product);
      else nPass++;
   endtask

   task automatic test_display;
      int          lat;
      int          pulses;
      logic [15:0] prod;
      logic        bAfter;
      logic [15:0] expProd;
      int          dig;
      logic [3:0]  nib;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      expProd = modelMult(8'h0C, 8'h0D);
      runMult(8'h0C, 8'h0D, lat, pulses, prod, bAfter);
      nChecks++;
      if (prod !== expProd) $display("[TB] FAIL display_product: got %h expected %h", prod, expProd);
      else nPass++;
      for (int k = 0; k < 32; k++) begin
         @(posedge clk);
         @(negedge clk);
         dig = (tbCyc / 4) % 4;
         nib = 4'(expProd >> (4 * dig));
         nChecks++;
         if (sm_wei !== 4'(1 << dig) || sm_duan !== segTab[nib])
            $display("[TB] FAIL display_scan cyc %0d: got wei %b duan %h expected %b %h",
                     tbCyc, sm_wei, sm_duan, 4'(1 << dig), segTab[nib]);
         else nPass++;
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0]  x1;
      logic [7:0]  y1;
      logic [7:0]  x2;
      logic [7:0]  y2;
      int          doneAt [2];
      logic [15:0] got [2];
      int          pulses;
      x1 = 8'($urandom_range(0, 255));
      y1 = 8'($urandom_range(0, 255));
      x2 = 8'($urandom_range(0, 255));
      y2 = 8'($urandom_range(0, 255));
      doneAt[0] = -1;
      doneAt[1] = -1;
      got[0]    = '0;
      got[1]    = '0;
      pulses    = 0;
      @(negedge clk);
      a     = x1;
      b     = y1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a = x2;
      b = y2;
      for (int k = 1; k <= 26; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            if (pulses < 2) begin
               doneAt[pulses] = k;
               got[pulses]    = product;
            end
            pulses++;
         end
         if (k == 10) start = 1'b0;
      end
      nChecks++;
      if (pulses != 2 || doneAt[0] != 9 || doneAt[1] != 19)
         $display("[TB] FAIL b2b_timing: got %0d pulses at %0d,%0d expected 2 at 9,19", pulses, doneAt[0], doneAt[1]);
      else nPass++;
      nChecks++;
      if (got[0] !== modelMult(x1, y1))
         $display("[TB] FAIL b2b_first: got %h expected %h", got[0], modelMult(x1, y1));
      else nPass++;
      nChecks++;
      if (got[1] !== modelMult(x2, y2))
         $display("[TB] FAIL b2b_second: got %h expected %h", got[1], modelMult(x2, y2));
      else nPass++;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_reset_during_run();
      test_display();
      test_back_to_back();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/seq_mult_display.md
SEQ_MULT_DISPLAY -- requirements
Module: seq_mult_display

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the operand width in bits (range 2..16).
REQ-002 The block SHALL have parameter DIGITS, default 4, meaning the number of 7-segment digits scanned (range 1..8).
REQ-003 The block SHALL have parameter SCAN_DIV, default 100000, meaning the number of clk cycles each digit is held (at least 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset, sampled on the clk rising edge.
REQ-006 The block SHALL have port start, input, 1 bit: a request to begin a multiply.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: the multiplicand and the multiplier.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a multiply is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the product is valid.
REQ-010 The block SHALL have port product, output, 2*WIDTH bits: the last completed result, held until the next completion.
REQ-011 The block SHALL have port sm_wei, output, DIGITS bits: one-hot, active-high digit select.
REQ-012 The block SHALL have port sm_duan, output, 8 bits: active-high segments, with bit0=a through bit6=g and bit7=dp.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN and FIN; busy SHALL be high in RUN and FIN only.
REQ-014 In IDLE with start=1, the block SHALL latch a and b, clear the accumulator and step counter, and enter RUN on the next edge.
REQ-015 In RUN, each cycle SHALL add the shifted multiplicand to the accumulator when the current multiplier bit is 1, then shift and increment the step counter.
REQ-016 The FSM SHALL leave RUN after exactly WIDTH cycles and enter FIN.
REQ-017 In FIN, the block SHALL load product from the accumulator, pulse done for exactly one cycle, and return to IDLE.
REQ-018 Latency SHALL be fixed: with start sampled at edge 0, done and the new product are visible after edge WIDTH+1, regardless of operand values (no early exit).
REQ-019 The block SHALL ignore start while busy=1; the latched operands SHALL be unaffected by changes on a and b during RUN.
REQ-020 start held high continuously SHALL produce back-to-back multiplies, each starting on the IDLE cycle after FIN.
REQ-021 The accumulator SHALL be 2*WIDTH bits wide; the unsigned result SHALL never overflow.
REQ-022 The scan counter SHALL count 0..SCAN_DIV-1; on wrap, the digit index SHALL advance 0..DIGITS-1 and then return to 0.
REQ-023 sm_wei SHALL be a registered one-hot value where bit i is high while digit i is shown.
REQ-024 Digit i SHALL show hex nibble product[4i+3:4i]; nibbles beyond bit 2*WIDTH-1 SHALL show 0.
REQ-025 The segment encoding SHALL be standard hexadecimal 0-F, with dp always 0.
REQ-026 The display SHALL reflect product only, never the in-progress accumulator.

Reset
REQ-027 With rst_n=0 at an edge, the block SHALL go to IDLE with busy=0, done=0, product=0, scan counter=0, digit index=0, sm_wei=one-hot bit0 and sm_duan=0x3F (the "0" pattern).
REQ-028 A reset during RUN or FIN SHALL abort the multiply with no done pulse; product SHALL become 0.
REQ-029 When start=1 and rst_n=0 occur together, reset SHALL win.

Configuration
REQ-030 With MULT_SIGNED_EN defined, a, b and product SHALL be treated as two's complement: magnitudes are multiplied and the result is negated when the signs differ, with the same latency.
REQ-031 With MULT_SIGNED_EN undefined, all operands and the product SHALL be unsigned.

Verification
REQ-032 Scenario: WIDTH=8, start with a=0x0C, b=0x0D -> done after edge 9, product=0x009C, busy low afterwards.
REQ-033 Scenario: a=0xFF, b=0xFF unsigned -> product=0xFE01; a=0x00, b=0xAB -> product=0x0000 with the same 9-cycle latency.
REQ-034 Scenario: pulse start again at cycle 3 of RUN with different operands -> ignored, first result unchanged, exactly one done pulse.
REQ-035 Scenario: rst_n=0 at cycle 4 of RUN -> no done pulse, product=0, busy=0, sm_wei=0001, sm_duan=0x3F.
REQ-036 Scenario: SCAN_DIV=4, DIGITS=4, product=0x009C -> sm_wei walks 0001, 0010, 0100, 1000 every 4 clocks, with sm_duan 0x39 ("C"), 0x6F ("9"), 0x3F, 0x3F.
REQ-037 Scenario: a=0xFF, b=0x02 -> product=0xFFFE with MULT_SIGNED_EN defined, and 0x01FE without it.
